muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide sequencer owning the HI/LO register pair of the pipelined MIPS core.

---
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair; also services MTHI/MTLO.
// Define MULDIV_RADIX4_EN to retire two iterations per clock (WIDTH/2 cycles per op).
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hienE,
    input  logic             loenE,
    input  logic [WIDTH-1:0] wdataE,
    input  logic             rdhiloD,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stallmd
);

    typedef enum logic {IDLE, RUN} state_t;

`ifdef MULDIV_RADIX4_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2 - 1);
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`endif

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] operand;
    logic             isDiv;
    logic             fixHi;
    logic             fixLo;

    logic             signedOp;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [2*WIDTH-1:0] step1;
    logic [2*WIDTH-1:0] stepOut;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] resHi;
    logic [WIDTH-1:0] resLo;
    logic             lastIter;

    // Shift-add: {ah,al} shifts right, multiplicand added into the upper half.
    function automatic logic [2*WIDTH-1:0] mulStep(
        input logic [WIDTH-1:0] ah,
        input logic [WIDTH-1:0] al,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, ah} + (al[0] ? {1'b0, m} : '0);
        return {sum[WIDTH:1], sum[0], al[WIDTH-1:1]};
    endfunction

    // Restoring divide: ah is the partial remainder, al shifts dividend out / quotient in.
    function automatic logic [2*WIDTH-1:0] divStep(
        input logic [WIDTH-1:0] ah,
        input logic [WIDTH-1:0] al,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        sh   = {ah, al[WIDTH-1]};
        diff = sh - {1'b0, d};
        if (!diff[WIDTH]) begin
            return {diff[WIDTH-1:0], al[WIDTH-2:0], 1'b1};
        end
        return {sh[WIDTH-1:0], al[WIDTH-2:0], 1'b0};
    endfunction

    assign busy     = (state == RUN);
    assign stallmd  = busy & (startE | hienE | loenE | rdhiloD);
    assign lastIter = (count == LAST);

    always_comb begin
        signedOp = opE[0];
        aNeg     = signedOp & srcaE[WIDTH-1];
        bNeg     = signedOp & srcbE[WIDTH-1];
        aMag     = aNeg ? -srcaE : srcaE;
        bMag     = bNeg ? -srcbE : srcbE;
    end

    always_comb begin
        step1 = isDiv ? divStep(accHi, accLo, operand)
                      : mulStep(accHi, accLo, operand);
`ifdef MULDIV_RADIX4_EN
        stepOut = isDiv ? divStep(step1[2*WIDTH-1:WIDTH], step1[WIDTH-1:0], operand)
                        : mulStep(step1[2*WIDTH-1:WIDTH], step1[WIDTH-1:0], operand);
`else
        stepOut = step1;
`endif
        prod  = fixLo ? -stepOut : stepOut;
        resHi = prod[2*WIDTH-1:WIDTH];
        resLo = prod[WIDTH-1:0];
        if (isDiv) begin
            resHi = fixHi ? -stepOut[2*WIDTH-1:WIDTH] : stepOut[2*WIDTH-1:WIDTH];
            resLo = fixLo ? -stepOut[WIDTH-1:0] : stepOut[WIDTH-1:0];
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (startE) stateNext = RUN;
            RUN:  if (lastIter) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            isDiv   <= 1'b0;
            fixHi   <= 1'b0;
            fixLo   <= 1'b0;
        end else if (state == IDLE) begin
            if (hienE) hi <= wdataE;
            if (loenE) lo <= wdataE;
            if (startE) begin
                count   <= '0;
                isDiv   <= opE[1];
                accHi   <= '0;
                accLo   <= opE[1] ? aMag : bMag;
                operand <= opE[1] ? bMag : aMag;
                fixHi   <= aNeg;
                // Divide-by-zero keeps an all-ones quotient regardless of sign.
                fixLo   <= (aNeg ^ bNeg) & ~(opE[1] & (srcbE == '0));
            end
        end else begin
            accHi <= stepOut[2*WIDTH-1:WIDTH];
            accLo <= stepOut[WIDTH-1:0];
            count <= count + 1'b1;
            if (lastIter) begin
                hi    <= resHi;
                lo    <= resLo;
                count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus stall, MTHI/MTLO and reset sequences.
module tb_muldiv_sequencer;

    localparam int W = 32;
`ifdef MULDIV_RADIX4_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         startE;
    logic [1:0]   opE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         hienE;
    logic         loenE;
    logic [W-1:0] wdataE;
    logic         rdhiloD;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         stallmd;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .hienE(hienE), .loenE(loenE),
        .wdataE(wdataE), .rdhiloD(rdhiloD), .hi(hi), .lo(lo),
        .busy(busy), .stallmd(stallmd)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int n, output bit stable);
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        @(negedge clk);
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        startE = 1'b0;
        h0 = hi; l0 = lo; n = 0; stable = 1'b1;
        while (busy && n < 200) begin
            n++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    typedef struct {
        string      nm;
        logic [1:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        bit stable;
        int stallBad;

        tbl[0]  = '{"multu max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1]  = '{"mult -7*3",  2'b01, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[2]  = '{"div -7/2",   2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{"divu 100/0", 2'b10, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
        tbl[4]  = '{"div ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5]  = '{"divu 100/7", 2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[6]  = '{"mult -5*-6", 2'b01, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30};
        tbl[7]  = '{"div 7/-2",   2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        tbl[8]  = '{"div -100/0", 2'b11, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
        tbl[9]  = '{"multu shft", 2'b00, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800};
        tbl[10] = '{"mult minsq", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[11] = '{"divu x/1",   2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

        reset = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
        hienE = 1'b0; loenE = 1'b0; wdataE = '0; rdhiloD = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset stallmd", stallmd, 0);

        for (int i = 0; i < 12; i++) begin
            runOp(tbl[i].op, tbl[i].a, tbl[i].b, n, stable);
            check({tbl[i].nm, " latency"}, n, LAT);
            check({tbl[i].nm, " hilo stable"}, stable, 1);
            check({tbl[i].nm, " hi"}, hi, tbl[i].eh);
            check({tbl[i].nm, " lo"}, lo, tbl[i].el);
        end

        // MTHI alone, then MTHI+MTLO together while idle
        hienE = 1'b1; wdataE = 32'h1234;
        #1 check("mthi idle stall", stallmd, 0);
        @(negedge clk);
        hienE = 1'b0;
        check("mthi hi", hi, 32'h1234);
        check("mthi lo kept", lo, 32'hFFFFFFFF);
        hienE = 1'b1; loenE = 1'b1; wdataE = 32'h5A5A;
        @(negedge clk);
        hienE = 1'b0; loenE = 1'b0;
        check("both hi", hi, 32'h5A5A);
        check("both lo", lo, 32'h5A5A);

        // MULT with MFHI in D from cycle 5, MTLO at 7, restart attempt at 10
        @(negedge clk);
        startE = 1'b1; opE = 2'b01; srcaE = 32'hFFFFFFF9; srcbE = 32'd3;
        @(negedge clk);
        startE = 1'b0;
        n = 0; stallBad = 0;
        while (busy && n < 200) begin
            n++;
            case (n)
                5:  rdhiloD = 1'b1;
                7:  begin loenE = 1'b1; wdataE = 32'hDEAD; end
                8:  loenE = 1'b0;
                10: begin startE = 1'b1; opE = 2'b10; srcaE = 32'd9; srcbE = 32'd3; end
                11: startE = 1'b0;
                default: ;
            endcase
            #1;
            if (stallmd !== (n >= 5)) stallBad++;
            if (n == 7) check("mtlo busy stall", stallmd, 1);
            if (n == 10) check("start busy stall", stallmd, 1);
            @(negedge clk);
        end
        startE = 1'b0; loenE = 1'b0;
        check("stall track", stallBad, 0);
        check("stall latency", n, LAT);
        #1 check("stall idle", stallmd, 0);
        check("stall hi", hi, 32'hFFFFFFFF);
        check("stall lo", lo, 32'hFFFFFFEB);
        rdhiloD = 1'b0;
        @(negedge clk);
        check("no restart", busy, 0);

        // async reset in the middle of a DIVU
        @(negedge clk);
        startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd7;
        @(negedge clk);
        startE = 1'b0;
        repeat (11) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        check("abort stallmd", stallmd, 0);
        @(negedge clk);
        reset = 1'b0;
        runOp(2'b10, 32'd1000, 32'd3, n, stable);
        check("post reset latency", n, LAT);
        check("post reset hi", hi, 1);
        check("post reset lo", lo, 333);

        // MTHI lands in the same cycle a MULTU starts; result overwrites it
        hienE = 1'b1; wdataE = 32'hAAAA;
        startE = 1'b1; opE = 2'b00; srcaE = 32'd3; srcbE = 32'd4;
        @(negedge clk);
        hienE = 1'b0; startE = 1'b0;
        check("start+mthi hi", hi, 32'hAAAA);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("start+mthi latency", n, LAT);
        check("start+mthi res hi", hi, 0);
        check("start+mthi res lo", lo, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
